// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite ROM fetch path.
package sprite_pkg;

  localparam int unsigned REQ_P1    = 0;
  localparam int unsigned REQ_P2    = 1;
  localparam int unsigned REQ_CAR   = 2;
  localparam int unsigned REQ_MONEY = 3;

  localparam int unsigned SPR_NUM_REQ = 4;
  localparam int unsigned SPR_IDX_W   = 2;
  localparam int unsigned SPR_ADDR_W  = 12;
  localparam int unsigned SPR_DATA_W  = 48;

  // One tag-pipeline entry; idx names the requester owning the ROM read in flight.
  typedef struct packed {
    logic                 valid;
    logic [SPR_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/sprite_fetch_arbiter_rr_pick.sv
// Combinational rotate-and-priority-encode: first set req bit at or after start, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int          j_int;
  logic [IW-1:0] j;

  // Walk from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = |req;
    j_int = 0;
    j     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      j_int = (int'(start) + k) % int'(N);
      j     = IW'(j_int);
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin sharing of the sprite ROM between scanline fetchers, with tagged responses,
// per-line grant count and a sticky overrun flag.
module sprite_fetch_arbiter import sprite_pkg::*; #(
  parameter int unsigned NUM_REQ = SPR_NUM_REQ,
  parameter int unsigned ADDR_W  = SPR_ADDR_W,
  parameter int unsigned DATA_W  = SPR_DATA_W,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      NewLine,
  input  logic [NUM_REQ-1:0]        Req,
  input  logic [NUM_REQ*ADDR_W-1:0] ReqAddr,
  output logic [NUM_REQ-1:0]        Gnt,
  output logic                      RomEn,
  output logic [ADDR_W-1:0]         RomAddr,
  input  logic [DATA_W-1:0]         RomData,
  output logic [NUM_REQ-1:0]        RespValid,
  output logic [DATA_W-1:0]         RespData,
  output logic [7:0]                FetchCount,
  output logic                      Overrun
);

  localparam int unsigned IW = SPR_IDX_W;

  logic [IW-1:0]      ptr_q, ptr_d, start, gidx, issue_idx_q;
  logic [NUM_REQ-1:0] req_eff;
  logic               grant;
  tag_t               pipe_q [ROM_LAT];

  assign req_eff = Reset ? '0 : Req;
  assign start   = NewLine ? '0 : ptr_q;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_eff),
    .start (start),
    .gnt   (Gnt),
    .idx   (gidx),
    .any   (grant)
  );

  always_comb begin
    ptr_d = start;
    if (grant) ptr_d = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);
  end

  // Issue stage, then ROM_LAT tag stages so the last stage lines up with RomData.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q       <= '0;
      RomEn       <= 1'b0;
      RomAddr     <= '0;
      issue_idx_q <= '0;
      for (int i = 0; i < int'(ROM_LAT); i++) pipe_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      RomEn       <= grant;
      issue_idx_q <= gidx;
      if (grant) RomAddr <= ReqAddr[gidx*ADDR_W +: ADDR_W];
      pipe_q[0] <= '{valid: RomEn, idx: issue_idx_q};
      for (int i = 1; i < int'(ROM_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RespValid <= '0;
      RespData  <= '0;
    end else if (pipe_q[ROM_LAT-1].valid) begin
      RespValid <= NUM_REQ'(1) << pipe_q[ROM_LAT-1].idx;
      RespData  <= RomData;
    end else begin
      RespValid <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      FetchCount <= '0;
      Overrun    <= 1'b0;
    end else begin
      if (NewLine)                            FetchCount <= grant ? 8'd1 : 8'd0;
      else if (grant && FetchCount != 8'hFF)  FetchCount <= FetchCount + 8'd1;
      if (NewLine && |(Req & ~Gnt))           Overrun    <= 1'b1;
    end
  end

endmodule

// File: doc/sprite_fetch_arbiter.md
# sprite_fetch_arbiter

Round-robin arbiter that shares one synchronous sprite-bitmap ROM between the per-scanline sprite fetchers (player 1, player 2, car, money). Each fetcher requests one 16-pixel sprite row at a time. The arbiter issues at most one ROM address per cycle and returns the row data, tagged to the requester, a fixed number of cycles later. It sits between the sprite fetch units and the sprite ROM, upstream of the color mapper's palette-index inputs. It also reports per-line fetch activity and a sticky overrun flag when fetching does not finish before the next line starts.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; index 0 = P1, 1 = P2, 2 = car, 3 = money.
- ADDR_W, 12: sprite ROM address width.
- DATA_W, 48: ROM row width (16 px × 3-bit color code).
- ROM_LAT, 2: cycles from RomAddr being driven to the matching RomData; minimum 1.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- NewLine  in  1  one-cycle pulse at the start of each horizontal blank.
- Req  in  NUM_REQ  per-requester request level.
- ReqAddr  in  NUM_REQ*ADDR_W  flattened addresses; slice i = [i*ADDR_W +: ADDR_W].
- Gnt  out  NUM_REQ  one-hot grant, combinational, in the same cycle as the request.
- RomEn  out  1  registered; RomAddr is valid in this cycle.
- RomAddr  out  ADDR_W  registered ROM address.
- RomData  in  DATA_W  ROM output, valid ROM_LAT cycles after the matching RomAddr.
- RespValid  out  NUM_REQ  registered one-hot response strobe.
- RespData  out  DATA_W  registered row data for the requester flagged by RespValid.
- FetchCount  out  8  grants since the last NewLine, saturating at 255.
- Overrun  out  1  sticky flag: a request was left pending at NewLine.

## Operation
- **Priority pointer.** Register ptr (log2 NUM_REQ bits); reset value 0.
- **Search start.** Start index s = 0 if NewLine is high in this cycle, otherwise s = ptr.
- **Grant.** Gnt selects the first i with Req[i]=1, searching s, s+1, … modulo NUM_REQ. Gnt = 0 if no Req bit is set.
- **Pointer update.** On a grant of index g, ptr ← (g+1) mod NUM_REQ. With no grant, ptr ← s.
- **Requester rule.** A requester holds Req and ReqAddr stable until it sees Gnt. In the cycle after Gnt it may drop Req or present a new address. ReqAddr is ignored when Req=0.
- **Issue.** On a grant, RomEn ← 1, RomAddr ← ReqAddr[g], and tag g enters the tag pipeline. With no grant, RomEn ← 0 and RomAddr holds its previous value.
- **Tag pipeline.** ROM_LAT stages, each holding a valid bit and a requester index, aligned with RomData. When the final stage is valid: RespValid ← onehot(tag) and RespData ← RomData. Otherwise RespValid ← 0 and RespData holds.
- **NewLine effects.**
  - Does not flush in-flight fetches; they return normally.
  - FetchCount ← (grant this cycle ? 1 : 0).
  - If (Req & ~Gnt) ≠ 0 in that cycle, Overrun ← 1.
- **FetchCount.** Otherwise increments by 1 per grant, saturating at 255.
- **Overrun.** Cleared only by Reset.
- **Reset.** Has priority over NewLine and grants. It takes effect at the clock edge:
  - ptr, FetchCount and Overrun ← 0.
  - All tag stages invalid.
  - RomEn, RomAddr, RespValid and RespData ← 0.
  - Gnt is forced to 0 while Reset is high.
  - Reset in the middle of a fetch discards in-flight responses; no RespValid is produced for them.

## Timing
- Grant in cycle t → RomEn/RomAddr in cycle t+1 → RomData in cycle t+1+ROM_LAT → RespValid/RespData in cycle t+2+ROM_LAT. This is 4 cycles at ROM_LAT=2.
- Throughput is 1 grant per cycle. Back-to-back responses to the same or different requesters are allowed, in grant order.
- No backpressure on responses; requesters must always accept RespValid.

## Structure
- sprite_pkg holds:
  - constants REQ_P1=0, REQ_P2=1, REQ_CAR=2, REQ_MONEY=3;
  - SPR_ADDR_W=12 and SPR_DATA_W=48;
  - a typedef for the tag-pipeline entry {valid, idx}.
- Sub-module rr_pick: a combinational rotate-and-priority-encode. Inputs are Req and s; outputs are a one-hot grant, the index g, and an any flag.
- The parent module holds ptr, the tag pipeline, the counters and the output registers.

## Test plan
- **Single request.** Reset, then Req=4'b0001 with ReqAddr[0]=12'h0A3 for 1 cycle → Gnt=0001 in that cycle, RomEn=1/RomAddr=0A3 in the next cycle, RespValid=0001 with RespData equal to ROM row 0A3 four cycles after the grant (ROM_LAT=2); FetchCount=1.
- **Round-robin order.** Req=1111 held, every requester re-requesting immediately → grants 0,1,2,3,0,1… one per cycle; responses return in the same order, each 4 cycles after its grant.
- **NewLine restarts at 0.** ptr=2 with Req=1111 when NewLine pulses → Gnt=0001 in that cycle; Overrun=1 the next cycle and stays 1 through later NewLines until Reset.
- **Mid-flight Reset.** Grant a fetch, assert Reset 2 cycles later → no RespValid ever appears for it; all outputs read 0 the cycle after Reset.
- **Saturation and line reset.** 300 consecutive grants with no NewLine → FetchCount holds at 255. Then NewLine with no request → FetchCount=0.
- **ROM_LAT=1 build.** Repeat the single-request scenario → response arrives 3 cycles after the grant.
